dot11_tx_psdu_framer: RTL and testbench

Transmit-side counterpart of the receive byte/FCS path. Takes a legacy (11a/g) rate/length header request and a PSDU payload byte stream, and appends the CRC-32 FCS. It emits the scrambled DATA-field bit stream in transmit order: SERVICE, payload, FCS, tail, pad. The output is ready for the convolutional encoder and sits between the MAC-side byte source and the TX FEC chain.

---
 rtl/dot11_tx_psdu_framer.sv | 178 +++++++++++++++++
 tb/tb_dot11_tx_psdu_framer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dot11_tx_psdu_framer.sv
// dot11_tx_psdu_framer
// Builds the legacy OFDM DATA-field bit stream for one PSDU:
//   SERVICE (16 zeros), payload (LSB first), CRC-32 FCS, 6 tail bits, pad.
//   Every bit is scrambled with x^7+x^4+1. The tail bits are then forced to zero.
// Ports:
//   clock, reset                  : clock and asynchronous active-high reset
//   start, pkt_rate, pkt_len,
//   scram_seed                    : packet request (sampled only while idle)
//   start_err, busy, done         : request status and end-of-packet pulse
//   byte_in/_valid/_ready         : payload byte stream (PSDU minus FCS)
//   bit_out/_valid/_ready         : scrambled serial output toward the encoder
//   fcs_out                       : transmitted FCS, bits [7:0] sent first
//   n_ofdm_sym                    : DATA symbols emitted so far in this packet
module dot11_tx_psdu_framer #(
  parameter logic [6:0] DEFAULT_SEED = 7'b1011101
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  pkt_rate,
  input  logic [11:0] pkt_len,
  input  logic [6:0]  scram_seed,
  output logic        start_err,
  output logic        busy,
  input  logic [7:0]  byte_in,
  input  logic        byte_in_valid,
  output logic        byte_in_ready,
  output logic        bit_out,
  output logic        bit_out_valid,
  input  logic        bit_out_ready,
  output logic [31:0] fcs_out,
  output logic [10:0] n_ofdm_sym,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SERVICE, S_DATA, S_FCS, S_TAIL, S_PAD, S_DONE
  } state_t;

  state_t      state, state_next;
  logic [3:0]  rate_q;
  logic [11:0] bytes_left;   // payload bytes not yet accepted
  logic [7:0]  buf_byte;
  logic [2:0]  buf_idx;
  logic        buf_full;
  logic [5:0]  bit_cnt;      // bit position inside SERVICE/FCS/TAIL
  logic [7:0]  sym_cnt;      // bit position inside the current OFDM symbol
  logic [6:0]  scr;
  logic [31:0] crc;
  logic [31:0] crc_upd;
  logic [7:0]  n_dbps;
  logic        start_ok, accept, xfer, sym_wrap, fb, in_bit, byte_acc;

  function automatic logic [7:0] dbps_of(input logic [3:0] r);
    case (r)
      4'b1011: dbps_of = 8'd24;
      4'b1111: dbps_of = 8'd36;
      4'b1010: dbps_of = 8'd48;
      4'b1110: dbps_of = 8'd72;
      4'b1001: dbps_of = 8'd96;
      4'b1101: dbps_of = 8'd144;
      4'b1000: dbps_of = 8'd192;
      4'b1100: dbps_of = 8'd216;
      default: dbps_of = 8'd0;
    endcase
  endfunction

  assign n_dbps   = dbps_of(rate_q);
  assign start_ok = (dbps_of(pkt_rate) != 8'd0) && (pkt_len >= 12'd5);
  assign accept   = (state == S_IDLE) && start && start_ok;
  assign fb       = scr[6] ^ scr[3];
  assign xfer     = bit_out_valid && bit_out_ready;
  assign sym_wrap = (sym_cnt == n_dbps - 8'd1);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign crc_upd  = {1'b0, crc[31:1]} ^ ((crc[0] ^ in_bit) ? 32'hEDB88320 : 32'h0);

  // The buffer may be refilled in the same cycle its last bit leaves, so a
  // continuously valid source sees no bubbles inside S_DATA.
  assign byte_in_ready = (state == S_DATA) && (bytes_left != 12'd0) &&
                         (!buf_full || (xfer && buf_idx == 3'd7));
  assign byte_acc      = byte_in_valid && byte_in_ready;

  // Output datapath: unscrambled input bit and valid per state.
  always_comb begin
    in_bit        = 1'b0;
    bit_out_valid = 1'b0;
    case (state)
      S_SERVICE: bit_out_valid = 1'b1;
      S_DATA: begin
        bit_out_valid = buf_full;
        in_bit        = buf_byte[buf_idx];
      end
      S_FCS: begin
        bit_out_valid = 1'b1;
        in_bit        = fcs_out[bit_cnt[4:0]];
      end
      S_TAIL:  bit_out_valid = 1'b1;
      S_PAD:   bit_out_valid = 1'b1;
      default: ;
    endcase
    // Tail goes out as zeros even though the scrambler keeps running.
    bit_out = bit_out_valid && (state != S_TAIL) && (in_bit ^ fb);
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (accept) state_next = S_SERVICE;
      S_SERVICE: if (xfer && bit_cnt == 6'd15) state_next = S_DATA;
      S_DATA:    if (xfer && buf_idx == 3'd7 && bytes_left == 12'd0) state_next = S_FCS;
      S_FCS:     if (xfer && bit_cnt == 6'd31) state_next = S_TAIL;
      S_TAIL:    if (xfer && bit_cnt == 6'd5) state_next = sym_wrap ? S_DONE : S_PAD;
      S_PAD:     if (xfer && sym_wrap) state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      start_err  <= 1'b0;
      rate_q     <= 4'd0;
      bytes_left <= 12'd0;
      buf_byte   <= 8'd0;
      buf_idx    <= 3'd0;
      buf_full   <= 1'b0;
      bit_cnt    <= 6'd0;
      sym_cnt    <= 8'd0;
      scr        <= DEFAULT_SEED;
      crc        <= 32'hFFFFFFFF;
      fcs_out    <= 32'd0;
      n_ofdm_sym <= 11'd0;
    end else begin
      state     <= state_next;
      start_err <= (state == S_IDLE) && start && !start_ok;
      if (accept) begin
        rate_q     <= pkt_rate;
        bytes_left <= pkt_len - 12'd4;
        scr        <= (scram_seed == 7'd0) ? DEFAULT_SEED : scram_seed;
        crc        <= 32'hFFFFFFFF;
        n_ofdm_sym <= 11'd0;
        sym_cnt    <= 8'd0;
        bit_cnt    <= 6'd0;
        buf_full   <= 1'b0;
        buf_idx    <= 3'd0;
      end
      if (xfer) begin
        scr     <= {scr[5:0], fb};
        bit_cnt <= (state_next != state) ? 6'd0 : bit_cnt + 6'd1;
        if (sym_wrap) begin
          sym_cnt    <= 8'd0;
          n_ofdm_sym <= n_ofdm_sym + 11'd1;
        end else begin
          sym_cnt <= sym_cnt + 8'd1;
        end
      end
      if (state == S_DATA) begin
        if (xfer) begin
          crc     <= crc_upd;
          buf_idx <= buf_idx + 3'd1;
          if (buf_idx == 3'd7) buf_full <= 1'b0;
          // Load the FCS including the final payload bit's CRC update.
          if (buf_idx == 3'd7 && bytes_left == 12'd0) fcs_out <= ~crc_upd;
        end
        if (byte_acc) begin
          buf_byte   <= byte_in;
          buf_idx    <= 3'd0;
          buf_full   <= 1'b1;
          bytes_left <= bytes_left - 12'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dot11_tx_psdu_framer.sv
// Testbench for dot11_tx_psdu_framer: expected bit streams are queued when a
// packet is requested, and a monitor pops and compares every transferred bit.
module tb_dot11_tx_psdu_framer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  pkt_rate;
  logic [11:0] pkt_len;
  logic [6:0]  scram_seed;
  logic        start_err, busy, byte_in_ready, bit_out, bit_out_valid, done;
  logic [7:0]  byte_in;
  logic        byte_in_valid;
  logic        bit_out_ready;
  logic [31:0] fcs_out;
  logic [10:0] n_ofdm_sym;

  int n_vec = 0;
  int n_bad = 0;
  bit exp_q[$];
  bit cap[$];
  bit sb_on = 1'b0;
  logic [7:0] pl [0:255];

  always #5 clock = ~clock;

  dot11_tx_psdu_framer dut (
    .clock(clock), .reset(reset), .start(start), .pkt_rate(pkt_rate),
    .pkt_len(pkt_len), .scram_seed(scram_seed), .start_err(start_err),
    .busy(busy), .byte_in(byte_in), .byte_in_valid(byte_in_valid),
    .byte_in_ready(byte_in_ready), .bit_out(bit_out),
    .bit_out_valid(bit_out_valid), .bit_out_ready(bit_out_ready),
    .fcs_out(fcs_out), .n_ofdm_sym(n_ofdm_sym), .done(done)
  );

  // Monitor: one comparison per transferred output bit.
  always @(negedge clock) begin
    if (sb_on && bit_out_valid && bit_out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL bit_extra pos=%0d got=%0b expected=none", cap.size(), bit_out);
      end else begin
        bit e;
        e = exp_q.pop_front();
        if (bit_out !== e) begin
          n_bad++;
          $display("FAIL bit_stream pos=%0d got=%0b expected=%0b", cap.size(), bit_out, e);
        end
      end
      cap.push_back(bit_out);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  function automatic int model_dbps(input logic [3:0] r);
    case (r)
      4'b1011: return 24;   4'b1111: return 36;
      4'b1010: return 48;   4'b1110: return 72;
      4'b1001: return 96;   4'b1101: return 144;
      4'b1000: return 192;  4'b1100: return 216;
      default: return 0;
    endcase
  endfunction

  // Reference stream: SERVICE, payload LSB first, FCS, zero tail, scrambled pad.
  task automatic build_expected(input logic [3:0] rate, input logic [11:0] len,
                                input logic [6:0] seed, output logic [31:0] fcs);
    logic [6:0]  s;
    logic [31:0] c;
    bit          f, d;
    int          nd, cnt;
    s   = (seed == 7'd0) ? 7'b1011101 : seed;
    nd  = model_dbps(rate);
    c   = 32'hFFFFFFFF;
    for (int i = 0; i < int'(len) - 4; i++)
      for (int b = 0; b < 8; b++) begin
        d = pl[i][b];
        f = c[0] ^ d;
        c = c >> 1;
        if (f) c = c ^ 32'hEDB88320;
      end
    fcs = ~c;
    cnt = 0;
    for (int k = 0; k < 16 + 8 * (int'(len) - 4) + 32 + 6; k++) begin
      if (k < 16) d = 1'b0;
      else if (k < 16 + 8 * (int'(len) - 4)) d = pl[(k - 16) / 8][(k - 16) % 8];
      else if (k < 16 + 8 * int'(len)) d = fcs[k - 16 - 8 * (int'(len) - 4)];
      else d = 1'b0;
      f = s[6] ^ s[3];
      s = {s[5:0], f};
      exp_q.push_back((k >= 16 + 8 * int'(len)) ? 1'b0 : (d ^ f));
      cnt++;
    end
    while (cnt % nd != 0) begin
      f = s[6] ^ s[3];
      s = {s[5:0], f};
      exp_q.push_back(f);
      cnt++;
    end
  endtask

  task automatic run_pkt(input string tag, input logic [3:0] rate, input logic [11:0] len,
                         input logic [6:0] seed, input bit rnd, input int busy_start_at,
                         input int abort_at, input int exp_total, input logic [10:0] exp_sym);
    logic [31:0] mfcs;
    int          idx, cyc, base;
    bit          got_done, acc;
    exp_q.delete();
    cap.delete();
    build_expected(rate, len, seed, mfcs);
    sb_on = 1'b1;
    @(posedge clock); #1;
    start = 1'b1; pkt_rate = rate; pkt_len = len; scram_seed = seed;
    @(posedge clock); #1;
    start = 1'b0;
    chk({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
    chk({tag, "_valid_after_start"}, {31'd0, bit_out_valid}, 32'd1);
    idx = 0; cyc = 0; got_done = 1'b0;
    byte_in = pl[0]; byte_in_valid = 1'b1; bit_out_ready = 1'b1;
    while (!got_done && cyc < 6000) begin
      @(negedge clock);
      acc = byte_in_valid && byte_in_ready;
      if (done) got_done = 1'b1;
      if (busy_start_at > 0 && cyc == busy_start_at + 1)
        chk({tag, "_no_err_when_busy"}, {31'd0, start_err}, 32'd0);
      @(posedge clock); #1;
      cyc++;
      if (acc) idx++;
      if (abort_at > 0 && cyc == abort_at) begin
        reset = 1'b1;
        #1;
        chk({tag, "_reset_valid"}, {31'd0, bit_out_valid}, 32'd0);
        chk({tag, "_reset_busy"}, {31'd0, busy}, 32'd0);
        sb_on = 1'b0;
        exp_q.delete();
        byte_in_valid = 1'b0;
        @(posedge clock); #1;
        chk({tag, "_reset_no_done"}, {31'd0, done}, 32'd0);
        reset = 1'b0;
        return;
      end
      byte_in       = pl[idx];
      byte_in_valid = (idx < int'(len) - 4) && (!rnd || $urandom_range(0, 3) != 0);
      bit_out_ready = !rnd || ($urandom_range(0, 1) == 1);
      start         = (busy_start_at > 0 && cyc == busy_start_at);
      pkt_rate      = 4'b1100;
      pkt_len       = 12'd5;
    end
    start = 1'b0; byte_in_valid = 1'b0; bit_out_ready = 1'b1;
    sb_on = 1'b0;
    chk({tag, "_done_seen"}, {31'd0, got_done}, 32'd1);
    chk({tag, "_total_bits"}, cap.size(), exp_total);
    chk({tag, "_queue_drained"}, exp_q.size(), 32'd0);
    chk({tag, "_n_ofdm_sym"}, {21'd0, n_ofdm_sym}, {21'd0, exp_sym});
    chk({tag, "_fcs"}, fcs_out, mfcs);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    base = 16 + 8 * int'(len);
    if (cap.size() >= base + 6)
      for (int k = 0; k < 6; k++) chk({tag, "_tail_zero"}, {31'd0, cap[base + k]}, 32'd0);
    else
      chk({tag, "_tail_present"}, cap.size(), base + 6);
    $display("packet %s rate=%b len=%0d bits=%0d sym=%0d fcs=0x%08h", tag, rate, len,
             cap.size(), n_ofdm_sym, fcs_out);
  endtask

  task automatic check_first16(input string tag);
    logic [15:0] g;
    g = 16'd0;
    for (int i = 0; i < 16 && i < cap.size(); i++) g = {g[14:0], cap[i]};
    chk({tag, "_first16"}, {16'd0, g}, {16'd0, 16'b0000111011110010});
  endtask

  task automatic reject(input string tag, input logic [3:0] rate, input logic [11:0] len);
    @(posedge clock); #1;
    start = 1'b1; pkt_rate = rate; pkt_len = len; scram_seed = 7'd0;
    @(posedge clock); #1;
    start = 1'b0;
    chk({tag, "_start_err"}, {31'd0, start_err}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bit_out_valid}, 32'd0);
    @(posedge clock); #1;
    chk({tag, "_err_one_cycle"}, {31'd0, start_err}, 32'd0);
    $display("reject %s rate=%b len=%0d", tag, rate, len);
  endtask

  task automatic load_ascii();
    for (int i = 0; i < 256; i++) pl[i] = 8'h00;
    for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pkt_rate = 4'd0; pkt_len = 12'd0; scram_seed = 7'd0;
    byte_in = 8'd0; byte_in_valid = 1'b0; bit_out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_start_err", {31'd0, start_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_bit_out", {31'd0, bit_out}, 32'd0);
    chk("rst_valid", {31'd0, bit_out_valid}, 32'd0);
    chk("rst_byte_ready", {31'd0, byte_in_ready}, 32'd0);
    chk("rst_fcs", fcs_out, 32'd0);
    chk("rst_nsym", {21'd0, n_ofdm_sym}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    load_ascii();
    run_pkt("crc_check", 4'b1011, 12'd13, 7'b1111111, 1'b0, 0, 0, 144, 11'd6);
    chk("crc_check_fcs_const", fcs_out, 32'hCBF43926);
    check_first16("crc_check");

    pl[0] = 8'hA5;
    run_pkt("short_r6", 4'b1011, 12'd5, 7'd0, 1'b0, 20, 0, 72, 11'd3);
    run_pkt("short_r54", 4'b1100, 12'd5, 7'h2B, 1'b0, 0, 0, 216, 11'd1);

    for (int i = 0; i < 256; i++) pl[i] = 8'(i * 7 + 3);
    run_pkt("long_rand", 4'b1100, 12'd100, 7'h55, 1'b1, 0, 0, 864, 11'd4);

    reject("bad_rate", 4'b0000, 12'd13);
    reject("short_len", 4'b1011, 12'd4);

    load_ascii();
    run_pkt("mid_reset", 4'b1011, 12'd13, 7'b1111111, 1'b0, 0, 40, 144, 11'd6);
    run_pkt("after_reset", 4'b1011, 12'd13, 7'b1111111, 1'b0, 0, 0, 144, 11'd6);
    chk("after_reset_fcs_const", fcs_out, 32'hCBF43926);
    check_first16("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
